fuel_dispense_counter: RTL and testbench

Dispense controller and volume accumulator for one pump nozzle. It edge-detects flow-sensor pulses, prescales them into display units, and drives the pump valve until a latched preset is reached, the operator stops, or the counter saturates. Its `lit` and `start` outputs feed the seven-digit volume display stage directly downstream. Together with that stage, it closes the loop between the flow sensor, the valve and the display.

---
 rtl/fuel_dispense_counter.sv | 143 ++++++++++++++
 tb/tb_fuel_dispense_counter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/fuel_dispense_counter.sv
// rtl/fuel_dispense_counter.sv - nozzle dispense controller and volume accumulator
//
// Purpose:
//   Edge-detects flow-sensor pulses and prescales them into whole display
//   units. Drives the pump valve from a start request until a preset latched
//   at start is reached, the operator stops, or the volume count saturates.
//   o_lit and o_start feed the seven-digit volume display stage.
//
// Ports:
//   i_clk         rising-edge clock
//   i_rst         synchronous active-high reset
//   i_start_btn   start request (debounced, synchronised), rising edge acts
//   i_stop_btn    stop request (debounced, synchronised), level-sensitive
//   i_preset      target volume in units, 0 = no limit, latched at start
//   i_flow_pulse  flow sensor output (synchronised)
//   o_lit         dispensed volume in whole units, 0..MAX_LIT
//   o_start       high while dispensing
//   o_valve       pump valve enable
//   o_done        one-cycle pulse when a dispense ends
module fuel_dispense_counter #(
  parameter int unsigned PULSES_PER_UNIT = 100,
  parameter int unsigned MAX_LIT         = 9999999
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start_btn,
  input  logic        i_stop_btn,
  input  logic [23:0] i_preset,
  input  logic        i_flow_pulse,
  output logic [23:0] o_lit,
  output logic        o_start,
  output logic        o_valve,
  output logic        o_done
);

  localparam logic [15:0] PRESCALE_LAST = 16'(PULSES_PER_UNIT - 1);
  localparam logic [23:0] LIT_MAX       = 24'(MAX_LIT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PUMPING = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_prescale;
  logic [15:0] w_prescale_next;
  logic [23:0] r_preset;
  logic [23:0] w_preset_next;
  logic [23:0] r_lit;
  logic [23:0] w_lit_next;
  logic        r_start_q;
  logic        r_flow_q;
  logic        r_start;
  logic        r_valve;
  logic        r_done;
  logic        w_start_rise;
  logic        w_flow_rise;

  assign w_start_rise = i_start_btn & ~r_start_q;
  assign w_flow_rise  = i_flow_pulse & ~r_flow_q;

  always_comb begin
    w_state_next    = r_state;
    w_prescale_next = r_prescale;
    w_preset_next   = r_preset;
    w_lit_next      = r_lit;

    case (r_state)
      S_IDLE: begin
        // A stop held during the start edge vetoes the start.
        if (w_start_rise && !i_stop_btn) begin
          w_state_next    = S_PUMPING;
          w_lit_next      = 24'd0;
          w_prescale_next = 16'd0;
          w_preset_next   = i_preset;
        end
      end

      S_PUMPING: begin
        // Counting happens before the stop decision so a pulse arriving
        // with the stop is still billed.
        if (w_flow_rise) begin
          if (r_prescale == PRESCALE_LAST) begin
            w_prescale_next = 16'd0;
            if (r_lit != LIT_MAX) begin
              w_lit_next = r_lit + 24'd1;
            end
          end else begin
            w_prescale_next = r_prescale + 16'd1;
          end
        end

        if (i_stop_btn ||
            ((r_preset != 24'd0) && (w_lit_next >= r_preset)) ||
            (w_lit_next == LIT_MAX)) begin
          w_state_next = S_DONE;
        end
      end

      S_DONE: begin
        w_state_next = S_IDLE;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_prescale <= 16'd0;
      r_preset   <= 24'd0;
      r_lit      <= 24'd0;
      r_start_q  <= 1'b0;
      r_flow_q   <= 1'b0;
      r_start    <= 1'b0;
      r_valve    <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_prescale <= w_prescale_next;
      r_preset   <= w_preset_next;
      r_lit      <= w_lit_next;
      r_start_q  <= i_start_btn;
      r_flow_q   <= i_flow_pulse;
      // Outputs are registered from the next state so they change on the
      // same edge as the state itself.
      r_start    <= (w_state_next == S_PUMPING);
      r_valve    <= (w_state_next == S_PUMPING);
      r_done     <= (w_state_next == S_DONE);
    end
  end

  assign o_lit   = r_lit;
  assign o_start = r_start;
  assign o_valve = r_valve;
  assign o_done  = r_done;

endmodule

// File: tb/tb_fuel_dispense_counter.sv
// tb/tb_fuel_dispense_counter.sv - directed bench for fuel_dispense_counter
module tb_fuel_dispense_counter;

  logic        clk = 1'b0;
  logic        rst;

  logic        a_start_btn, a_stop_btn, a_flow;
  logic [23:0] a_preset;
  logic [23:0] a_lit;
  logic        a_start, a_valve, a_done;

  logic        b_start_btn, b_stop_btn, b_flow;
  logic [23:0] b_preset;
  logic [23:0] b_lit;
  logic        b_start, b_valve, b_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fuel_dispense_counter #(.PULSES_PER_UNIT(4)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_start_btn(a_start_btn), .i_stop_btn(a_stop_btn),
    .i_preset(a_preset), .i_flow_pulse(a_flow),
    .o_lit(a_lit), .o_start(a_start), .o_valve(a_valve), .o_done(a_done)
  );

  fuel_dispense_counter #(.PULSES_PER_UNIT(1), .MAX_LIT(5)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_start_btn(b_start_btn), .i_stop_btn(b_stop_btn),
    .i_preset(b_preset), .i_flow_pulse(b_flow),
    .o_lit(b_lit), .o_start(b_start), .o_valve(b_valve), .o_done(b_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input int lit, input bit st, input bit vl, input bit dn);
    chk({tag, " lit"},   32'(a_lit),   32'(lit));
    chk({tag, " start"}, 32'(a_start), 32'(st));
    chk({tag, " valve"}, 32'(a_valve), 32'(vl));
    chk({tag, " done"},  32'(a_done),  32'(dn));
  endtask

  // One full flow pulse on dut_a: high for one cycle, low for one.
  task automatic pulse_a();
    a_flow = 1'b1; tick();
    a_flow = 1'b0; tick();
  endtask

  initial begin
    int exp_lit;

    rst = 1'b1;
    a_start_btn = 1'b0; a_stop_btn = 1'b0; a_flow = 1'b0; a_preset = 24'd0;
    b_start_btn = 1'b0; b_stop_btn = 1'b0; b_flow = 1'b0; b_preset = 24'd0;
    tick(); tick();
    chk_a("reset", 0, 1'b0, 1'b0, 1'b0);
    chk("reset b lit", 32'(b_lit), 32'd0);
    rst = 1'b0;
    tick();

    // Preset 3 with 4 pulses per unit.
    a_preset = 24'd3;
    a_start_btn = 1'b1; tick();
    chk_a("p3 start", 0, 1'b1, 1'b1, 1'b0);
    a_start_btn = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      a_flow = 1'b1; tick();
      exp_lit = i / 4;
      if (i == 12) chk_a("p3 reach", 3, 1'b0, 1'b0, 1'b1);
      else         chk_a($sformatf("p3 pulse%0d", i), exp_lit, 1'b1, 1'b1, 1'b0);
      a_flow = 1'b0; tick();
      if (i == 12) chk_a("p3 idle", 3, 1'b0, 1'b0, 1'b0);
    end
    pulse_a(); pulse_a(); pulse_a(); pulse_a();
    chk_a("p3 post flow", 3, 1'b0, 1'b0, 1'b0);

    // Back-to-back: new start with no limit, 10 pulses then stop.
    a_preset = 24'd0;
    a_start_btn = 1'b1; tick();
    chk_a("b2b start clears", 0, 1'b1, 1'b1, 1'b0);
    a_start_btn = 1'b0;
    for (int i = 0; i < 10; i++) pulse_a();
    chk_a("nolimit 10 pulses", 2, 1'b1, 1'b1, 1'b0);
    a_stop_btn = 1'b1; tick();
    chk_a("op stop", 2, 1'b0, 1'b0, 1'b1);
    a_stop_btn = 1'b0; tick();
    chk_a("op stop idle", 2, 1'b0, 1'b0, 1'b0);

    // Remainder dropped: a fresh dispense needs 4 full pulses per unit.
    a_start_btn = 1'b1; tick();
    chk_a("coinc start", 0, 1'b1, 1'b1, 1'b0);
    pulse_a(); pulse_a(); pulse_a();
    // start_btn re-pulsed while pumping must not clear the prescaler.
    a_start_btn = 1'b0; tick();
    a_start_btn = 1'b1; tick();
    chk_a("restart ignored", 0, 1'b1, 1'b1, 1'b0);
    a_flow = 1'b1; a_stop_btn = 1'b1; tick();
    chk_a("stop with 4th rise", 1, 1'b0, 1'b0, 1'b1);
    a_flow = 1'b0; a_stop_btn = 1'b0; a_start_btn = 1'b0; tick();
    chk_a("coinc idle", 1, 1'b0, 1'b0, 1'b0);

    // Saturation on dut_b: MAX_LIT=5, one pulse per unit.
    b_start_btn = 1'b1; tick();
    chk("sat start valve", 32'(b_valve), 32'd1);
    b_start_btn = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      b_flow = 1'b1; tick();
      exp_lit = (i < 5) ? i : 5;
      chk($sformatf("sat lit%0d", i), 32'(b_lit), 32'(exp_lit));
      if (i == 5) begin
        chk("sat done", 32'(b_done), 32'd1);
        chk("sat valve", 32'(b_valve), 32'd0);
      end
      b_flow = 1'b0; tick();
    end
    chk("sat final valve", 32'(b_valve), 32'd0);

    // Reset during pumping with lit=7.
    a_start_btn = 1'b1; tick();
    a_start_btn = 1'b0;
    for (int i = 0; i < 28; i++) pulse_a();
    chk_a("pre-reset", 7, 1'b1, 1'b1, 1'b0);
    rst = 1'b1; tick();
    chk_a("mid reset", 0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0; tick();

    // Normal start after reset, preset 2.
    a_preset = 24'd2;
    a_start_btn = 1'b1; tick();
    chk_a("post-reset start", 0, 1'b1, 1'b1, 1'b0);
    a_start_btn = 1'b0;
    for (int i = 0; i < 7; i++) pulse_a();
    chk_a("post-reset 7 pulses", 1, 1'b1, 1'b1, 1'b0);
    a_flow = 1'b1; tick();
    chk_a("post-reset reach", 2, 1'b0, 1'b0, 1'b1);
    a_flow = 1'b0; tick();
    chk_a("post-reset idle", 2, 1'b0, 1'b0, 1'b0);

    // Start and stop at the same edge: stays idle, lit kept.
    a_start_btn = 1'b1; a_stop_btn = 1'b1; tick();
    chk_a("start+stop", 2, 1'b0, 1'b0, 1'b0);
    a_start_btn = 1'b0; a_stop_btn = 1'b0; tick();
    chk_a("start+stop after", 2, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
